// File: rtl/sat_counter_n.sv
// Parametrised N-bit saturating up/down counter with bounds, step, load and region flags.
// Define SATCNT_WRAP_EN to honour wrap_mode (wrap at bounds instead of saturating).
module sat_counter_n #(
    parameter int WIDTH     = 4,
    parameter int MIN_VAL   = 0,
    parameter int MAX_VAL   = 2**WIDTH - 1,
    parameter int RESET_VAL = MIN_VAL,
    parameter int THRESH    = 2**(WIDTH - 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             up_down,
    input  logic [WIDTH-1:0] step,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             clear,
    input  logic             wrap_mode,
    output logic [WIDTH-1:0] count,
    output logic             at_min,
    output logic             at_max,
    output logic             above,
    output logic             sat_pulse
);

    // Extended width leaves headroom for count+step and the wrap offsets.
    localparam int EW = WIDTH + 2;
    localparam logic [EW-1:0]    MIN_E   = EW'(MIN_VAL);
    localparam logic [EW-1:0]    MAX_E   = EW'(MAX_VAL);
    localparam logic [EW-1:0]    TH_E    = EW'(THRESH);
    localparam logic [EW-1:0]    ONE_E   = EW'(1);
    localparam logic [WIDTH-1:0] MIN_C   = WIDTH'(MIN_VAL);
    localparam logic [WIDTH-1:0] MAX_C   = WIDTH'(MAX_VAL);
    localparam logic [WIDTH-1:0] RESET_C = WIDTH'(RESET_VAL);

    typedef enum logic [1:0] {
        ST_MIN = 2'd0,
        ST_MID = 2'd1,
        ST_MAX = 2'd2
    } state_t;

    state_t           state_r;
    state_t           next_state_s;
    logic [WIDTH-1:0] count_r;
    logic [WIDTH-1:0] next_count_s;
    logic             sat_pulse_r;
    logic             next_pulse_s;
    logic             wrap_en_s;
    logic [EW-1:0]    count_e_s;
    logic [EW-1:0]    step_e_s;
    logic [EW-1:0]    sum_s;
    logic [EW-1:0]    wrap_up_s;
    logic [EW-1:0]    wrap_dn_top_s;
    logic [EW-1:0]    wrap_dn_sub_s;
    logic [EW-1:0]    wrap_dn_s;
    logic             under_s;

    function automatic state_t region_of(input logic [WIDTH-1:0] v);
        if (v == MIN_C) begin
            region_of = ST_MIN;
        end else if (v == MAX_C) begin
            region_of = ST_MAX;
        end else begin
            region_of = ST_MID;
        end
    endfunction

    function automatic logic [WIDTH-1:0] clamp(input logic [WIDTH-1:0] v);
        if ({2'b00, v} < MIN_E) begin
            clamp = MIN_C;
        end else if ({2'b00, v} > MAX_E) begin
            clamp = MAX_C;
        end else begin
            clamp = v;
        end
    endfunction

`ifdef SATCNT_WRAP_EN
    assign wrap_en_s = wrap_mode;
`else
    logic unused_wrap_s;
    assign unused_wrap_s = wrap_mode;
    assign wrap_en_s     = 1'b0;
`endif

    assign count_e_s     = {2'b00, count_r};
    assign step_e_s      = {2'b00, step};
    assign sum_s         = count_e_s + step_e_s;
    assign wrap_up_s     = sum_s - MAX_E - ONE_E + MIN_E;
    assign under_s       = count_e_s < (step_e_s + MIN_E);
    // Down wrap is MAX - (MIN - diff - 1), rearranged to stay non-negative.
    assign wrap_dn_top_s = MAX_E + count_e_s + ONE_E;
    assign wrap_dn_sub_s = MIN_E + step_e_s;
    assign wrap_dn_s     = wrap_dn_top_s - wrap_dn_sub_s;

    // Next count and saturation pulse: clear > load > step > hold.
    always_comb begin
        next_count_s = count_r;
        next_pulse_s = 1'b0;
        if (clear) begin
            next_count_s = RESET_C;
        end else if (load) begin
            next_count_s = clamp(load_value);
        end else if (enable) begin
            if (up_down) begin
                if (sum_s > MAX_E) begin
                    next_pulse_s = 1'b1;
                    if (wrap_en_s && (wrap_up_s <= MAX_E)) begin
                        next_count_s = wrap_up_s[WIDTH-1:0];
                    end else begin
                        next_count_s = MAX_C;
                    end
                end else begin
                    next_count_s = sum_s[WIDTH-1:0];
                end
            end else begin
                if (under_s) begin
                    next_pulse_s = 1'b1;
                    if (wrap_en_s && (wrap_dn_top_s >= wrap_dn_sub_s) && (wrap_dn_s >= MIN_E)) begin
                        next_count_s = wrap_dn_s[WIDTH-1:0];
                    end else begin
                        next_count_s = MIN_C;
                    end
                end else begin
                    next_count_s = count_r - step;
                end
            end
        end else begin
            next_count_s = count_r;
        end
        next_state_s = region_of(next_count_s);
    end

    // Count, region state and pulse registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_r     <= RESET_C;
            state_r     <= region_of(RESET_C);
            sat_pulse_r <= 1'b0;
        end else begin
            count_r     <= next_count_s;
            state_r     <= next_state_s;
            sat_pulse_r <= next_pulse_s;
        end
    end

    assign count     = count_r;
    assign at_min    = (state_r == ST_MIN);
    assign at_max    = (state_r == ST_MAX);
    assign above     = (count_e_s >= TH_E);
    assign sat_pulse = sat_pulse_r;

endmodule

// File: tb/tb_sat_counter_n.sv
// Scoreboard bench: two counters (default bounds and 2..12) share stimulus and are
// checked against an integer reference model of the counting rules.
module tb_sat_counter_n;
    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         enable = 1'b0;
    logic         up_down = 1'b0;
    logic         load = 1'b0;
    logic         clear = 1'b0;
    logic         wrap_mode = 1'b0;
    logic [W-1:0] step = '0;
    logic [W-1:0] load_value = '0;

    logic [W-1:0] count0, count1;
    logic         at_min0, at_max0, above0, pulse0;
    logic         at_min1, at_max1, above1, pulse1;

    sat_counter_n #(.WIDTH(W)) dut0 (
        .clk(clk), .rst(rst), .enable(enable), .up_down(up_down), .step(step),
        .load(load), .load_value(load_value), .clear(clear), .wrap_mode(wrap_mode),
        .count(count0), .at_min(at_min0), .at_max(at_max0), .above(above0), .sat_pulse(pulse0)
    );

    sat_counter_n #(.WIDTH(W), .MIN_VAL(2), .MAX_VAL(12), .RESET_VAL(5), .THRESH(8)) dut1 (
        .clk(clk), .rst(rst), .enable(enable), .up_down(up_down), .step(step),
        .load(load), .load_value(load_value), .clear(clear), .wrap_mode(wrap_mode),
        .count(count1), .at_min(at_min1), .at_max(at_max1), .above(above1), .sat_pulse(pulse1)
    );

    always #5 clk = ~clk;

    typedef struct {
        int       c0;
        bit [3:0] f0;
        int       c1;
        bit [3:0] f1;
    } exp_t;

    exp_t q[$];
    int   n_vec = 0;
    int   n_bad = 0;
    int   m0 = 0;
    int   m1 = 5;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Reference behaviour of one counter, in plain integer arithmetic.
    task automatic model(input int cnt, input int mn, input int mx, input int rv,
                         input bit clr, input bit ld, input int lv, input bit en,
                         input bit ud, input int st, input bit wm,
                         output int nc, output bit p);
        bit wrap;
        int v;
`ifdef SATCNT_WRAP_EN
        wrap = wm;
`else
        wrap = 1'b0;
`endif
        nc = cnt;
        p  = 1'b0;
        if (clr) begin
            nc = rv;
        end else if (ld) begin
            nc = (lv < mn) ? mn : ((lv > mx) ? mx : lv);
        end else if (en) begin
            v = ud ? cnt + st : cnt - st;
            if (v > mx) begin
                p  = 1'b1;
                nc = wrap ? mn + (v - mx - 1) : mx;
            end else if (v < mn) begin
                p  = 1'b1;
                nc = wrap ? mx - (mn - v - 1) : mn;
            end else begin
                nc = v;
            end
        end
    endtask

    task automatic drive(input bit clr, input bit ld, input int lv, input bit en,
                         input bit ud, input int st, input bit wm);
        exp_t e;
        int   n0, n1;
        bit   p0, p1;
        @(negedge clk);
        clear      = clr;
        load       = ld;
        load_value = W'(lv);
        enable     = en;
        up_down    = ud;
        step       = W'(st);
        wrap_mode  = wm;
        model(m0, 0, 15, 0, clr, ld, lv, en, ud, st, wm, n0, p0);
        model(m1, 2, 12, 5, clr, ld, lv, en, ud, st, wm, n1, p1);
        e.c0 = n0;
        e.f0 = {n0 == 0, n0 == 15, n0 >= 8, p0};
        e.c1 = n1;
        e.f1 = {n1 == 2, n1 == 12, n1 >= 8, p1};
        q.push_back(e);
        m0 = n0;
        m1 = n1;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 0, 1'b0, 1'b0, 0, 1'b0);
    endtask

    task automatic reset_check();
        check("rst_count0", 32'(count0), 32'd0);
        check("rst_flags0", {28'd0, at_min0, at_max0, above0, pulse0}, 32'b1000);
        check("rst_count1", 32'(count1), 32'd5);
        check("rst_flags1", {28'd0, at_min1, at_max1, above1, pulse1}, 32'b0000);
        m0 = 0;
        m1 = 5;
    endtask

    // Monitor: pops the expectation for each edge that had stimulus.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                check("count0", 32'(count0), 32'(e.c0));
                check("flags0", {28'd0, at_min0, at_max0, above0, pulse0}, {28'd0, e.f0});
                check("count1", 32'(count1), 32'(e.c1));
                check("flags1", {28'd0, at_min1, at_max1, above1, pulse1}, {28'd0, e.f1});
            end
        end
    end

    initial begin
        #12;
        reset_check();
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 6; i++) drive(1'b0, 1'b0, 0, 1'b1, 1'b1, 3, 1'b0);
        for (int i = 0; i < 4; i++) drive(1'b0, 1'b0, 0, 1'b1, 1'b0, 5, 1'b0);
        for (int w = 1; w >= 0; w--) begin
            drive(1'b0, 1'b1, 11, 1'b0, 1'b0, 0, 1'b0);
            drive(1'b0, 1'b0, 0, 1'b1, 1'b1, 4, 1'(w));
            drive(1'b0, 1'b1, 3, 1'b0, 1'b0, 0, 1'b0);
            drive(1'b0, 1'b0, 0, 1'b1, 1'b0, 3, 1'(w));
        end
        drive(1'b1, 1'b1, 7, 1'b1, 1'b1, 3, 1'b0);
        drive(1'b0, 1'b1, 14, 1'b1, 1'b1, 3, 1'b0);
        drive(1'b0, 1'b1, 15, 1'b0, 1'b0, 0, 1'b0);
        drive(1'b0, 1'b0, 0, 1'b1, 1'b1, 0, 1'b0);
        for (int i = 0; i < 3; i++) idle();

        drive(1'b1, 1'b0, 0, 1'b0, 1'b0, 0, 1'b0);
        for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 0, 1'b1, 1'b1, 3, 1'b0);
        idle();
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        reset_check();
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 400; i++) begin
            drive(($urandom_range(19) == 0), ($urandom_range(9) == 0), $urandom_range(15),
                  ($urandom_range(3) != 0), 1'($urandom_range(1)), $urandom_range(10),
                  1'($urandom_range(1)));
        end
        idle();
        repeat (3) @(posedge clk);
        #2;
        check("queue_drained", 32'(q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
